// File: rtl/mem_pkg.sv
// Shared definitions for the split-capable byte-addressed memory: access
// length encodings, FSM state type and the data word width.
package mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] LEN_B   = 2'b00;
  localparam logic [1:0] LEN_H   = 2'b01;
  localparam logic [1:0] LEN_W   = 2'b10;
  localparam logic [1:0] LEN_BAD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for a two-word window: byte enables and store
// data rotated to the byte offset, and load data extracted and extended.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]          offset,
  input  logic [1:0]          length,
  input  logic                sign,
  input  logic [WORD_W-1:0]   wdata,
  input  logic [WORD_W-1:0]   lo_word,
  input  logic [WORD_W-1:0]   hi_word,
  output logic [7:0]          byte_en,
  output logic [2*WORD_W-1:0] wdata_lanes,
  output logic [WORD_W-1:0]   rdata,
  output logic                crossing,
  output logic                misaligned
);

  logic [3:0]        mask;
  logic [WORD_W-1:0] raw;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves a value unassigned and no latch is inferred.
    mask  = 4'b0000;
    rdata = '0;
    raw   = 32'({hi_word, lo_word} >> {offset, 3'b000});

    case (length)
      LEN_B: begin
        mask  = 4'b0001;
        rdata = sign ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
      end
      LEN_H: begin
        mask  = 4'b0011;
        rdata = sign ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
      end
      LEN_W: begin
        mask  = 4'b1111;
        rdata = raw;
      end
      default: ;
    endcase
  end

  assign byte_en     = 8'(mask) << offset;
  assign wdata_lanes = {32'b0, wdata} << {offset, 3'b000};
  // Any enable in the upper half means the access spills into the next word.
  assign crossing    = |byte_en[7:4];
  assign misaligned  = ((length == LEN_H) && offset[0]) ||
                       ((length == LEN_W) && (offset != 2'b00));

endmodule

// File: rtl/memory_split_rv.sv
// Byte-addressed word memory with a valid/ready request port; word-crossing
// accesses are either trapped or split across two cycles.
module memory_split_rv
  import mem_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int MISALIGN_MODE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_length,
  input  logic        req_sign,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORD_AW = ADDR_W - 2;
  localparam int DEPTH   = 1 << WORD_AW;

  logic [WORD_W-1:0] mem [DEPTH];

  state_t state, state_nxt;

  logic               sv_wr, sv_sign;
  logic [WORD_AW-1:0] sv_w;
  logic [1:0]         sv_off, sv_len;
  logic [WORD_W-1:0]  sv_wdata;

  logic               in_split, accept, bad, go_split, we_lo, we_hi, rsp_fire;
  logic               cur_wr, cur_sign;
  logic [WORD_AW-1:0] cur_w, cur_w1;
  logic [1:0]         cur_off, cur_len;
  logic [WORD_W-1:0]  cur_wdata, lo_word, hi_word, rdata;
  logic [7:0]         byte_en;
  logic [2*WORD_W-1:0] wdata_lanes;
  logic               crossing, misaligned;
  logic               unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W];

  // In SPLIT the captured request drives the datapath; otherwise the live one.
  assign in_split  = (state == SPLIT);
  assign cur_wr    = in_split ? sv_wr    : req_wr;
  assign cur_sign  = in_split ? sv_sign  : req_sign;
  assign cur_off   = in_split ? sv_off   : req_addr[1:0];
  assign cur_len   = in_split ? sv_len   : req_length;
  assign cur_wdata = in_split ? sv_wdata : req_wdata;
  assign cur_w     = in_split ? sv_w     : req_addr[ADDR_W-1:2];
  assign cur_w1    = cur_w + WORD_AW'(1);

  assign lo_word = mem[cur_w];
  assign hi_word = mem[cur_w1];

  mem_lane_align u_align (
    .offset      (cur_off),
    .length      (cur_len),
    .sign        (cur_sign),
    .wdata       (cur_wdata),
    .lo_word     (lo_word),
    .hi_word     (hi_word),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata       (rdata),
    .crossing    (crossing),
    .misaligned  (misaligned)
  );

  assign accept   = req_valid && req_ready;
  assign bad      = !in_split &&
                    ((cur_len == LEN_BAD) || ((MISALIGN_MODE == 0) && misaligned));
  assign go_split = accept && !bad && crossing;
  assign we_lo    = accept && !bad && req_wr;
  assign we_hi    = in_split && !rst && sv_wr;
  assign rsp_fire = (accept && !go_split) || in_split;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_split) state_nxt = SPLIT;
      SPLIT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !rst;
  end

  // NOTE: the storage array has no reset; clearing 2^ADDR_W bytes is not
  // required and would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_lo && byte_en[b])     mem[cur_w][8*b +: 8]  <= wdata_lanes[8*b +: 8];
      if (we_hi && byte_en[b + 4]) mem[cur_w1][8*b +: 8] <= wdata_lanes[32 + 8*b +: 8];
    end
  end

  // Request capture is pure datapath; it is only read after a valid accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      sv_wr    <= req_wr;
      sv_sign  <= req_sign;
      sv_off   <= req_addr[1:0];
      sv_len   <= req_length;
      sv_wdata <= req_wdata;
      sv_w     <= req_addr[ADDR_W-1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b1;
      rsp_err   <= bad;
      rsp_rdata <= (cur_wr || bad) ? '0 : rdata;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
